// File: rtl/windowed_watchdog_timer.sv
// Windowed watchdog timer.
// Counts cycles while enabled. A service kick inside the legal window restarts
// the count. Reaching TIMEOUT-1 without a kick causes a bite: a registered
// reset pulse RST_PULSE cycles wide, plus a cause code and a saturating bite count.
// Optional macro WDT_WINDOW_EN makes a kick before WIN_OPEN an early-kick bite.
module windowed_watchdog_timer #(
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 100,
    parameter int WIN_OPEN  = 25,
    parameter int WARN_AT   = 80,
    parameter int RST_PULSE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wd_en,
    input  logic             kick,
    output logic             rst_o,
    output logic             warn_o,
    output logic [1:0]       cause_o,
    output logic [7:0]       bite_cnt_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam int     PW      = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    // Reject parameter sets that would let the counter wrap or the window invert.
    generate
        if (!(WIN_OPEN > 0 && WIN_OPEN <= WARN_AT && WARN_AT < TIMEOUT &&
              longint'(TIMEOUT) <= CNT_MAX && RST_PULSE >= 1)) begin : g_bad_params
            $error("windowed_watchdog_timer: illegal parameter combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WARN_PRE  = CNT_W'(WARN_AT - 1);
    localparam logic [PW-1:0]    PULSE_TOP = PW'(RST_PULSE - 1);

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_EARLY   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        BITE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    pulse_q;
    logic             rst_q;
    logic             warn_q;
    logic [1:0]       cause_q;
    logic [7:0]       bite_cnt_q;

    logic kick_ok;
    logic kick_early;

`ifdef WDT_WINDOW_EN
    assign kick_ok    = kick && (cnt_q >= CNT_W'(WIN_OPEN));
    assign kick_early = kick && !kick_ok;
`else
    assign kick_ok    = kick;
    assign kick_early = 1'b0;
`endif

    // Single FSM: state, counter and every output are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pulse_q    <= '0;
            rst_q      <= 1'b0;
            warn_q     <= 1'b0;
            cause_q    <= 2'b00;
            bite_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    warn_q <= 1'b0;
                    rst_q  <= 1'b0;
                    if (wd_en) state_q <= COUNT;
                end
                COUNT: begin
                    if (!wd_en) begin
                        // Disable wins over kick and expiry in the same cycle.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        warn_q  <= 1'b0;
                    end else if (kick_ok) begin
                        // Valid kick also wins over expiry at CNT_TOP.
                        cnt_q  <= '0;
                        warn_q <= 1'b0;
                    end else if (kick_early || cnt_q == CNT_TOP) begin
                        state_q <= BITE;
                        cnt_q   <= '0;
                        warn_q  <= 1'b0;
                        rst_q   <= 1'b1;
                        pulse_q <= '0;
                        cause_q <= kick_early ? CAUSE_EARLY : CAUSE_TIMEOUT;
                        if (bite_cnt_q != 8'hFF) bite_cnt_q <= bite_cnt_q + 8'd1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        warn_q <= (cnt_q >= WARN_PRE);
                    end
                end
                BITE: begin
                    // kick and wd_en are only looked at when the pulse ends.
                    cnt_q  <= '0;
                    warn_q <= 1'b0;
                    if (pulse_q == PULSE_TOP) begin
                        rst_q   <= 1'b0;
                        state_q <= wd_en ? COUNT : IDLE;
                    end else begin
                        pulse_q <= pulse_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    warn_q  <= 1'b0;
                    rst_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_o      = rst_q;
    assign warn_o     = warn_q;
    assign cause_o    = cause_q;
    assign bite_cnt_o = bite_cnt_q;
    assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_windowed_watchdog_timer.sv
// Directed bench for windowed_watchdog_timer (CNT_W=8, TIMEOUT=16, WIN_OPEN=4,
// WARN_AT=12, RST_PULSE=3). Expected values are hand-derived per scenario.
module tb_windowed_watchdog_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wd_en = 1'b0;
    logic       kick = 1'b0;
    logic       rst_o;
    logic       warn_o;
    logic [1:0] cause_o;
    logic [7:0] bite_cnt_o;
    logic [7:0] cnt_o;

    int total = 0;
    int bad   = 0;

    windowed_watchdog_timer #(
        .CNT_W(8), .TIMEOUT(16), .WIN_OPEN(4), .WARN_AT(12), .RST_PULSE(3)
    ) dut (
        .clk(clk), .rst(rst), .wd_en(wd_en), .kick(kick),
        .rst_o(rst_o), .warn_o(warn_o), .cause_o(cause_o),
        .bite_cnt_o(bite_cnt_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wd_en = 1'b0; kick = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cnt_o !== 8'd0)      begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
        total++; if (rst_o !== 1'b0)      begin bad++; $display("FAIL reset_rst_o got=%b exp=0", rst_o); end
        total++; if (warn_o !== 1'b0)     begin bad++; $display("FAIL reset_warn got=%b exp=0", warn_o); end
        total++; if (cause_o !== 2'b00)   begin bad++; $display("FAIL reset_cause got=%b exp=00", cause_o); end
        total++; if (bite_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_bite_cnt got=%0d exp=0", bite_cnt_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        wd_en = 1'b1;
        step();
        total++; if (cnt_o !== 8'd0) begin bad++; $display("FAIL to_first_cnt got=%0d exp=0", cnt_o); end
        for (int i = 1; i <= 15; i++) begin
            step();
            total++; if (cnt_o !== 8'(i)) begin bad++; $display("FAIL to_cnt step=%0d got=%0d exp=%0d", i, cnt_o, i); end
            total++; if (warn_o !== (i >= 12)) begin bad++; $display("FAIL to_warn step=%0d got=%b exp=%b", i, warn_o, (i >= 12)); end
            total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL to_early_bite step=%0d got=%b exp=0", i, rst_o); end
        end
        step();
        total++; if (rst_o !== 1'b1)      begin bad++; $display("FAIL to_bite got=%b exp=1", rst_o); end
        total++; if (cause_o !== 2'b01)   begin bad++; $display("FAIL to_cause got=%b exp=01", cause_o); end
        total++; if (bite_cnt_o !== 8'd1) begin bad++; $display("FAIL to_bite_cnt got=%0d exp=1", bite_cnt_o); end
        total++; if (warn_o !== 1'b0)     begin bad++; $display("FAIL to_bite_warn got=%b exp=0", warn_o); end
        for (int i = 2; i <= 3; i++) begin
            step();
            total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL to_pulse cyc=%0d got=%b exp=1", i, rst_o); end
        end
        step();
        total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL to_pulse_end got=%b exp=0", rst_o); end
        total++; if (cnt_o !== 8'd0) begin bad++; $display("FAIL to_restart0 got=%0d exp=0", cnt_o); end
        step();
        total++; if (cnt_o !== 8'd1) begin bad++; $display("FAIL to_restart1 got=%0d exp=1", cnt_o); end
        // Disable: cause must survive the toggle, kicks in IDLE do nothing.
        wd_en = 1'b0;
        step();
        total++; if (cnt_o !== 8'd0)    begin bad++; $display("FAIL to_idle_cnt got=%0d exp=0", cnt_o); end
        total++; if (cause_o !== 2'b01) begin bad++; $display("FAIL to_cause_hold got=%b exp=01", cause_o); end
        kick = 1'b1;
        step(); step();
        kick = 1'b0;
        total++; if (cnt_o !== 8'd0) begin bad++; $display("FAIL idle_kick_cnt got=%0d exp=0", cnt_o); end
        total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL idle_kick_rst got=%b exp=0", rst_o); end
        wd_en = 1'b1;
        step();
        total++; if (cause_o !== 2'b01) begin bad++; $display("FAIL to_cause_reen got=%b exp=01", cause_o); end
    endtask

    task automatic test_periodic_kick();
        int m;
        int peak;
        int cnt_err;
        int bites;
        int warns;
        do_reset();
        wd_en = 1'b1;
        step();
        m = 0; peak = 0; cnt_err = 0; bites = 0; warns = 0;
        for (int c = 0; c < 500; c++) begin
            kick = (m == 9);
            step();
            m = (m == 9) ? 0 : m + 1;
            if (cnt_o !== 8'(m)) cnt_err++;
            if (int'(cnt_o) > peak) peak = int'(cnt_o);
            if (rst_o !== 1'b0) bites++;
            if (warn_o !== 1'b0) warns++;
        end
        kick = 1'b0;
        total++; if (cnt_err != 0) begin bad++; $display("FAIL pk_cnt_track got=%0d exp=0 mismatching cycles", cnt_err); end
        total++; if (peak != 9)    begin bad++; $display("FAIL pk_peak got=%0d exp=9", peak); end
        total++; if (bites != 0)   begin bad++; $display("FAIL pk_bite got=%0d exp=0 bite cycles", bites); end
        total++; if (warns != 0)   begin bad++; $display("FAIL pk_warn got=%0d exp=0 warn cycles", warns); end
        total++; if (bite_cnt_o !== 8'd0) begin bad++; $display("FAIL pk_bite_cnt got=%0d exp=0", bite_cnt_o); end
    endtask

    task automatic test_early_kick();
        do_reset();
        wd_en = 1'b1;
        step(); step(); step();
        total++; if (cnt_o !== 8'd2) begin bad++; $display("FAIL ek_setup got=%0d exp=2", cnt_o); end
        kick = 1'b1;
        step();
        kick = 1'b0;
`ifdef WDT_WINDOW_EN
        total++; if (rst_o !== 1'b1)      begin bad++; $display("FAIL ek_bite got=%b exp=1", rst_o); end
        total++; if (cause_o !== 2'b10)   begin bad++; $display("FAIL ek_cause got=%b exp=10", cause_o); end
        total++; if (bite_cnt_o !== 8'd1) begin bad++; $display("FAIL ek_bite_cnt got=%0d exp=1", bite_cnt_o); end
`else
        total++; if (cnt_o !== 8'd0)    begin bad++; $display("FAIL ek_cnt got=%0d exp=0", cnt_o); end
        total++; if (rst_o !== 1'b0)    begin bad++; $display("FAIL ek_nobite got=%b exp=0", rst_o); end
        total++; if (cause_o !== 2'b00) begin bad++; $display("FAIL ek_cause got=%b exp=00", cause_o); end
        step();
        total++; if (cnt_o !== 8'd1) begin bad++; $display("FAIL ek_cnt_next got=%0d exp=1", cnt_o); end
`endif
    endtask

    task automatic test_limits();
        do_reset();
        wd_en = 1'b1;
        step();
        repeat (15) step();
        total++; if (cnt_o !== 8'd15) begin bad++; $display("FAIL lim_setup got=%0d exp=15", cnt_o); end
        kick = 1'b1;
        step();
        kick = 1'b0;
        total++; if (cnt_o !== 8'd0)      begin bad++; $display("FAIL lim_kick_cnt got=%0d exp=0", cnt_o); end
        total++; if (rst_o !== 1'b0)      begin bad++; $display("FAIL lim_kick_rst got=%b exp=0", rst_o); end
        total++; if (bite_cnt_o !== 8'd0) begin bad++; $display("FAIL lim_kick_bites got=%0d exp=0", bite_cnt_o); end
        total++; if (warn_o !== 1'b0)     begin bad++; $display("FAIL lim_kick_warn got=%b exp=0", warn_o); end
        repeat (8) step();
        total++; if (cnt_o !== 8'd8) begin bad++; $display("FAIL lim_cnt8 got=%0d exp=8", cnt_o); end
        wd_en = 1'b0; kick = 1'b1;
        step();
        kick = 1'b0;
        total++; if (cnt_o !== 8'd0)  begin bad++; $display("FAIL lim_dis_cnt got=%0d exp=0", cnt_o); end
        total++; if (warn_o !== 1'b0) begin bad++; $display("FAIL lim_dis_warn got=%b exp=0", warn_o); end
        step();
        total++; if (cnt_o !== 8'd0) begin bad++; $display("FAIL lim_idle_hold got=%0d exp=0", cnt_o); end
    endtask

    task automatic test_bite_reset();
        do_reset();
        wd_en = 1'b1;
        step();
        repeat (16) step();
        total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL br_bite got=%b exp=1", rst_o); end
        step();
        total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL br_bite2 got=%b exp=1", rst_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (rst_o !== 1'b0)      begin bad++; $display("FAIL br_rst_o got=%b exp=0", rst_o); end
        total++; if (cause_o !== 2'b00)   begin bad++; $display("FAIL br_cause got=%b exp=00", cause_o); end
        total++; if (bite_cnt_o !== 8'd0) begin bad++; $display("FAIL br_bite_cnt got=%0d exp=0", bite_cnt_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wd_en = 1'b1;
        step();
        // Bite n appears at step 16 + 19*(n-1): 16 count cycles + 3 pulse cycles.
        for (int i = 1; i <= 260 * 19; i++) begin
            step();
            if (i == 16 + 19 * 253) begin
                total++; if (bite_cnt_o !== 8'd254) begin bad++; $display("FAIL b2b_254 got=%0d exp=254", bite_cnt_o); end
            end
            if (i == 16 + 19 * 254) begin
                total++; if (bite_cnt_o !== 8'd255) begin bad++; $display("FAIL b2b_255 got=%0d exp=255", bite_cnt_o); end
            end
            if (i == 16 + 19 * 259) begin
                total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL b2b_last_bite got=%b exp=1", rst_o); end
            end
        end
        total++; if (bite_cnt_o !== 8'd255) begin bad++; $display("FAIL b2b_sat got=%0d exp=255", bite_cnt_o); end
        total++; if (cause_o !== 2'b01)     begin bad++; $display("FAIL b2b_cause got=%b exp=01", cause_o); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_periodic_kick();
        test_early_kick();
        test_limits();
        test_bite_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout_guard simulation exceeded time limit");
        $fatal(1);
    end

endmodule
